// File: rtl/int_to_float.sv
// -----------------------------------------------------------------------------
// int_to_float
//
// Converts a 12-bit two's-complement integer into the 13-bit floating-point
// format used by the downstream comparator and arithmetic blocks:
//
//     dout = {sign, exp[3:0], sig[7:0]}
//     value = (-1)^sign * 0.sig * 2^exp
//
// The significand carries an explicit leading one (sig[7] = 1 for every
// nonzero result). Zero is encoded as all zeros with a positive sign.
//
// Normalization is iterative: the magnitude is shifted left by one bit per
// clock until its MSB is set, decrementing the exponent each time. The four
// magnitude bits that fall below the 8-bit significand are truncated.
//
// Ports
//   clk        in   1   system clock, rising-edge active
//   reset      in   1   synchronous, active-high reset
//   start      in   1   conversion request, honoured only while ready = 1
//   din        in  12   two's-complement input, sampled on an accepted start
//   ready      out  1   high while idle; a start will be accepted
//   done_tick  out  1   one-cycle pulse; dout holds a fresh result
//   dout       out 13   float result, held until the next completion
//
// Timing (E0 = edge that accepts start, lz = leading zeros of |din|):
//   NORM occupies edges E1..E(lz+1); dout updates at E(lz+1); done_tick is
//   high for the following cycle; ready returns after E(lz+2).
// -----------------------------------------------------------------------------
module int_to_float (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [11:0] din,
    output logic        ready,
    output logic        done_tick,
    output logic [12:0] dout
);

    // Exponent loaded with the magnitude: a 12-bit integer read as 0.mag
    // needs a scale of 2^12 before any normalization shifts are applied.
    localparam logic [3:0] EXP_INIT = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NORM = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic        sign_reg,  sign_next;
    logic [3:0]  exp_reg,   exp_next;
    logic [11:0] mag_reg,   mag_next;
    logic [12:0] dout_reg,  dout_next;

    // Absolute value of the input. -2048 negates to itself (12'h800), which
    // read as unsigned is exactly 2048, so no extra bit is needed.
    logic [11:0] din_mag;
    assign din_mag = din[11] ? (~din + 12'd1) : din;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            sign_reg  <= 1'b0;
            exp_reg   <= 4'd0;
            mag_reg   <= 12'd0;
            dout_reg  <= 13'h0000;
        end else begin
            state_reg <= state_next;
            sign_reg  <= sign_next;
            exp_reg   <= exp_next;
            mag_reg   <= mag_next;
            dout_reg  <= dout_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and datapath update
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        sign_next  = sign_reg;
        exp_next   = exp_reg;
        mag_next   = mag_reg;
        dout_next  = dout_reg;

        unique case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    sign_next  = din[11];
                    mag_next   = din_mag;
                    exp_next   = EXP_INIT;
                    state_next = ST_NORM;
                end
            end

            ST_NORM: begin
                if (mag_reg == 12'd0) begin
                    // Zero has a single encoding; the sign is dropped.
                    dout_next  = 13'h0000;
                    state_next = ST_DONE;
                end else if (mag_reg[11]) begin
                    // Normalized: keep the top eight bits, drop the rest.
                    dout_next  = {sign_reg, exp_reg, mag_reg[11:4]};
                    state_next = ST_DONE;
                end else begin
                    // A nonzero magnitude reaches mag[11] after at most 11
                    // shifts, so the exponent bottoms out at 1 and never wraps.
                    mag_next = {mag_reg[10:0], 1'b0};
                    exp_next = exp_reg - 4'd1;
                end
            end

            ST_DONE: begin
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs (Moore)
    // -------------------------------------------------------------------------
    always_comb begin
        ready     = 1'b0;
        done_tick = 1'b0;
        unique case (state_reg)
            ST_IDLE: ready     = 1'b1;
            ST_DONE: done_tick = 1'b1;
            default: begin
                ready     = 1'b0;
                done_tick = 1'b0;
            end
        endcase
    end

    assign dout = dout_reg;

    // -------------------------------------------------------------------------
    // Invariants
    // -------------------------------------------------------------------------
    // ready and done_tick come from mutually exclusive states.
    a_ready_done_exclusive: assert property (
        @(posedge clk) disable iff (reset) !(ready && done_tick)
    );

    // While normalizing a nonzero magnitude the exponent stays at least 1.
    a_exp_no_underflow: assert property (
        @(posedge clk) disable iff (reset)
        (state_reg == ST_NORM && mag_reg != 12'd0) |-> (exp_reg != 4'd0)
    );

    // A completed nonzero result always carries its explicit leading one.
    a_leading_one: assert property (
        @(posedge clk) disable iff (reset)
        (state_reg == ST_DONE && dout_reg != 13'h0000) |-> dout_reg[7]
    );

endmodule

// File: tb/tb_int_to_float.sv
// -----------------------------------------------------------------------------
// tb_int_to_float
//
// Self-checking bench for int_to_float. Expected results come from a
// value-level model: |v| is doubled until it reaches 2048, counting the
// doublings, and the float fields are read off the scaled magnitude.
// Outputs are sampled on the falling clock edge; inputs are driven there too.
// -----------------------------------------------------------------------------
module tb_int_to_float;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [11:0] din;
    logic        ready;
    logic        done_tick;
    logic [12:0] dout;

    int errors = 0;
    int checks = 0;

    int_to_float dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .din       (din),
        .ready     (ready),
        .done_tick (done_tick),
        .dout      (dout)
    );

    always #5 clk = ~clk;

    // -------------------------------------------------------------------------
    // Single comparison point
    // -------------------------------------------------------------------------
    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference model
    // -------------------------------------------------------------------------
    // Float code of integer v, and start-to-done latency in clock edges.
    function automatic logic [12:0] ref_float(input int v, output int lat);
        int  m;
        int  e;
        logic s;
        lat = 1;
        if (v == 0) return 13'h0000;
        s = (v < 0);
        m = s ? -v : v;
        e = 12;
        while (m < 2048) begin
            m   = m * 2;
            e   = e - 1;
            lat = lat + 1;
        end
        return {s, e[3:0], m[11:4]};
    endfunction

    // Numeric value of a float code scaled by 2^8 (so it is an integer).
    function automatic int float_value(input logic [12:0] f);
        int mag;
        mag = int'(f[7:0]) << f[11:8];
        return f[12] ? -mag : mag;
    endfunction

    // -------------------------------------------------------------------------
    // One conversion. Entered and left on a falling edge with the DUT idle.
    // -------------------------------------------------------------------------
    task automatic convert(input logic [11:0] value, output logic [12:0] result,
                           output int lat);
        int k;
        bit seen;
        start = 1'b1;
        din   = value;
        @(negedge clk);               // E0 has accepted the request
        start = 1'b0;
        k     = 1;
        seen  = 1'b0;
        lat   = -1;
        while (!seen && k <= 20) begin
            if (done_tick) begin
                seen = 1'b1;
                lat  = k - 1;
            end else begin
                check_val("busy_ready_low", 32'(ready), 32'd0);
                din = 12'($urandom);   // must not disturb the conversion
                @(negedge clk);
                k++;
            end
        end
        if (!seen) check_val("done_timeout", 32'd0, 32'd1);
        result = dout;
        @(negedge clk);
        check_val("ready_after_done", 32'(ready), 32'd1);
        check_val("done_single_pulse", 32'(done_tick), 32'd0);
        check_val("dout_held", 32'(dout), 32'(result));
    endtask

    task automatic convert_and_check(input logic [11:0] value,
                                     output logic [12:0] result);
        int lat;
        int exp_lat;
        logic [12:0] exp_f;
        convert(value, result, lat);
        exp_f = ref_float(int'($signed(value)), exp_lat);
        $display("conv din=%0d dout=0x%04h lat=%0d (exp 0x%04h lat=%0d)",
                 $signed(value), result, lat, exp_f, exp_lat);
        check_val("dout", 32'(result), 32'(exp_f));
        check_val("latency", 32'(lat), 32'(exp_lat));
    endtask

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    logic [11:0] directed [6] = '{12'h000, 12'h800, 12'h7FF,
                                  12'h001, 12'hFFF, 12'h005};

    initial begin
        logic [12:0] r, fa, fb;
        logic [11:0] a, b;
        int          dn, first_k, second_k;
        logic [12:0] first_d, second_d;

        reset = 1'b1;
        start = 1'b0;
        din   = 12'h000;

        // Reset state
        repeat (3) @(negedge clk);
        check_val("rst_ready", 32'(ready), 32'd1);
        check_val("rst_done", 32'(done_tick), 32'd0);
        check_val("rst_dout", 32'(dout), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check_val("idle_ready", 32'(ready), 32'd1);
        check_val("idle_done", 32'(done_tick), 32'd0);

        // Directed corner values, issued back to back
        foreach (directed[i]) convert_and_check(directed[i], r);

        // Busy protection: request -2048 every cycle while din=1 converts
        start    = 1'b1;
        din      = 12'h001;
        dn       = 0;
        first_k  = -1;
        second_k = -1;
        first_d  = 13'h0;
        second_d = 13'h0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (done_tick) begin
                dn++;
                if (dn == 1) begin
                    first_k = k;
                    first_d = dout;
                end else begin
                    second_k = k;
                    second_d = dout;
                end
            end
            din = 12'h800;
        end
        start = 1'b0;
        $display("busy dones=%0d first=0x%04h@%0d second=0x%04h@%0d",
                 dn, first_d, first_k, second_d, second_k);
        check_val("busy_done_count", 32'(dn), 32'd2);
        check_val("busy_first_dout", 32'(first_d), 32'h0180);
        check_val("busy_first_lat", 32'(first_k - 1), 32'd12);
        check_val("busy_second_dout", 32'(second_d), 32'h1C80);
        check_val("busy_second_cycle", 32'(second_k), 32'd16);
        @(negedge clk);
        check_val("busy_idle_ready", 32'(ready), 32'd1);

        // Reset mid-conversion, with a start coincident with reset
        start = 1'b1;
        din   = 12'h001;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        din   = 12'h005;
        @(negedge clk);
        $display("midreset ready=%0d done=%0d dout=0x%04h", ready, done_tick, dout);
        check_val("midrst_ready", 32'(ready), 32'd1);
        check_val("midrst_done", 32'(done_tick), 32'd0);
        check_val("midrst_dout", 32'(dout), 32'd0);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check_val("midrst_start_ignored", 32'(ready), 32'd1);
        check_val("midrst_no_done", 32'(done_tick), 32'd0);
        convert_and_check(12'h005, r);

        // Random pairs, each converted and then ordered via the float values
        for (int n = 0; n < 25; n++) begin
            a = 12'($urandom_range(0, 4095));
            b = 12'($urandom_range(0, 4095));
            convert_and_check(a, fa);
            convert_and_check(b, fb);
            if (fa != fb)
                check_val("cmp_gt", 32'(float_value(fa) > float_value(fb)),
                          32'($signed(a) > $signed(b)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
